// File: rtl/cpu_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the datapath sequencing controller:
//   - ALU opcode constants (5-bit)
//   - controller state enumeration (ctrl_state_t)
//   - bus-strobe bundle (bus_strobe_t) driven by the controller each cycle
//   - opcode classification helpers (legality, multi-cycle ops)
// Build option: define ALU_SEQ_MULDIV_EN to make mul/div legal opcodes.
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; req_ready is high only while the controller is idle,
// and requests presented while busy are dropped, never queued.
// ----------------------------------------------------------------------------
package cpu_ctrl_pkg;

    localparam int OP_W  = 5;
    localparam int REG_W = 4;
    localparam int CNT_W = 4;

    localparam logic [OP_W-1:0] OP_NONE = 5'b00000;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b00101;
    localparam logic [OP_W-1:0] OP_SHRA = 5'b00110;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b00111;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b01000;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01001;
    localparam logic [OP_W-1:0] OP_AND  = 5'b01010;
    localparam logic [OP_W-1:0] OP_OR   = 5'b01011;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        T_RA   = 3'd1,
        T_EXEC = 3'd2,
        T_WB   = 3'd3,
        T_LO   = 3'd4,
        T_HI   = 3'd5,
        T_ERR  = 3'd6
    } ctrl_state_t;

    typedef struct packed {
        logic rf_out_en;
        logic y_in;
        logic z_in;
        logic zlo_out;
        logic zhi_out;
        logic rf_wr_en;
        logic lo_in;
        logic hi_in;
    } bus_strobe_t;

    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // Unary ops take no B operand, so the register file stays off the bus.
    function automatic logic is_unary(input logic [OP_W-1:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
            OP_AND, OP_OR, OP_NEG, OP_NOT: legal = 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
            OP_MUL, OP_DIV:                legal = 1'b1;
`endif
            default:                       legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_seq_timer.sv
// ----------------------------------------------------------------------------
// alu_seq_timer
// Loadable 4-bit down-counter that times how long the opcode is held on the
// ALU. Priority: clear > load > decrement. Decrement stops at zero.
// Ports:
//   clock, reset_n   clock / asynchronous active-low reset
//   i_clear          force count to 0
//   i_load           load i_load_val
//   i_load_val[3:0]  cycles to count
//   i_dec            decrement by one
//   o_tc             terminal count: current cycle is the last one (count==1)
// ----------------------------------------------------------------------------
module alu_seq_timer
    import cpu_ctrl_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign o_tc = (r_count == 4'd1);

endmodule

// File: rtl/alu_seq_ctrl.sv
// ----------------------------------------------------------------------------
// alu_seq_ctrl
// Sequences one ALU operation over a shared bus:
//   T_RA   read ra onto the bus, load Y
//   T_EXEC hold opcode on the ALU (1 cycle, or MUL_CYCLES / DIV_CYCLES),
//          read rb onto the bus, load Z on the last cycle
//   T_WB   Z[31:0] -> register rd, done       (single-result ops)
//   T_LO   Z[31:0] -> LO                      (mul/div)
//   T_HI   Z[63:32] -> HI, done               (mul/div)
//   T_ERR  illegal pulse for rejected opcodes
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; req_ready is high only in IDLE and requests while
// busy are dropped. All outputs decode from the registered state only.
// Build option: ALU_SEQ_MULDIV_EN enables mul/div and the T_LO/T_HI path.
// Ports:
//   clock, reset_n                  clock / async active-low reset
//   req_valid/req_ready             request handshake
//   req_op, req_ra, req_rb, req_rd  opcode and register indices
//   rf_rd_addr, rf_out_en           register-file read onto the bus
//   y_in, z_in                      load Y / load Z
//   alu_ops                         opcode to the ALU (0 outside T_EXEC)
//   zlo_out, zhi_out                drive Z halves onto the bus
//   rf_wr_en, rf_wr_addr            register-file write from the bus
//   lo_in, hi_in                    load LO / HI
//   done, illegal                   completion / rejection pulses
//   dbg_state                       current controller state
// ----------------------------------------------------------------------------
module alu_seq_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4
)
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OP_W-1:0]  req_op,
    input  logic [REG_W-1:0] req_ra,
    input  logic [REG_W-1:0] req_rb,
    input  logic [REG_W-1:0] req_rd,
    output logic [REG_W-1:0] rf_rd_addr,
    output logic             rf_out_en,
    output logic             y_in,
    output logic [OP_W-1:0]  alu_ops,
    output logic             z_in,
    output logic             zlo_out,
    output logic             zhi_out,
    output logic             rf_wr_en,
    output logic [REG_W-1:0] rf_wr_addr,
    output logic             lo_in,
    output logic             hi_in,
    output logic             done,
    output logic             illegal,
    output ctrl_state_t      dbg_state
);

    ctrl_state_t      r_state;
    ctrl_state_t      w_next_state;
    logic [OP_W-1:0]  r_op;
    logic [REG_W-1:0] r_ra;
    logic [REG_W-1:0] r_rb;
    logic [REG_W-1:0] r_rd;
    logic             w_accept;
    logic             w_tc;
    bus_strobe_t      w_strobe;

    // Mul/div lengths are only ever loaded when those opcodes reach T_RA,
    // which cannot happen unless the build makes them legal.
    function automatic logic [CNT_W-1:0] exec_len(input logic [OP_W-1:0] op);
        logic [CNT_W-1:0] len;
        if (op == OP_MUL) begin
            len = CNT_W'(MUL_CYCLES);
        end else if (op == OP_DIV) begin
            len = CNT_W'(DIV_CYCLES);
        end else begin
            len = 4'd1;
        end
        return len;
    endfunction

    assign w_accept = req_valid && (r_state == IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_op    <= '0;
            r_ra    <= '0;
            r_rb    <= '0;
            r_rd    <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_op <= req_op;
                r_ra <= req_ra;
                r_rb <= req_rb;
                r_rd <= req_rd;
            end
        end
    end

    // Loaded during T_RA so the count is valid on the first T_EXEC cycle.
    alu_seq_timer u_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_clear    (r_state == IDLE),
        .i_load     (r_state == T_RA),
        .i_load_val (exec_len(r_op)),
        .i_dec      (r_state == T_EXEC),
        .o_tc       (w_tc)
    );

    always_comb begin
        w_next_state = r_state;
        w_strobe     = '0;
        req_ready    = 1'b0;
        rf_rd_addr   = '0;
        alu_ops      = OP_NONE;
        rf_wr_addr   = '0;
        done         = 1'b0;
        illegal      = 1'b0;

        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next_state = op_is_legal(req_op) ? T_RA : T_ERR;
                end
            end
            T_RA: begin
                rf_rd_addr         = r_ra;
                w_strobe.rf_out_en = 1'b1;
                w_strobe.y_in      = 1'b1;
                w_next_state       = T_EXEC;
            end
            T_EXEC: begin
                alu_ops            = r_op;
                rf_rd_addr         = r_rb;
                w_strobe.rf_out_en = !is_unary(r_op);
                if (w_tc) begin
                    w_strobe.z_in = 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
                    w_next_state  = is_muldiv(r_op) ? T_LO : T_WB;
`else
                    w_next_state  = T_WB;
`endif
                end
            end
            T_WB: begin
                w_strobe.zlo_out  = 1'b1;
                w_strobe.rf_wr_en = 1'b1;
                rf_wr_addr        = r_rd;
                done              = 1'b1;
                w_next_state      = IDLE;
            end
`ifdef ALU_SEQ_MULDIV_EN
            T_LO: begin
                w_strobe.zlo_out = 1'b1;
                w_strobe.lo_in   = 1'b1;
                w_next_state     = T_HI;
            end
            T_HI: begin
                w_strobe.zhi_out = 1'b1;
                w_strobe.hi_in   = 1'b1;
                done             = 1'b1;
                w_next_state     = IDLE;
            end
`endif
            T_ERR: begin
                illegal      = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign rf_out_en = w_strobe.rf_out_en;
    assign y_in      = w_strobe.y_in;
    assign z_in      = w_strobe.z_in;
    assign zlo_out   = w_strobe.zlo_out;
    assign zhi_out   = w_strobe.zhi_out;
    assign rf_wr_en  = w_strobe.rf_wr_en;
    assign lo_in     = w_strobe.lo_in;
    assign hi_in     = w_strobe.hi_in;
    assign dbg_state = r_state;

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 2, number of cycles the multiply opcode is held on the ALU before Z capture (range 1-15).
REQ-002 SHALL have parameter DIV_CYCLES, default 4, number of cycles the divide opcode is held on the ALU before Z capture (range 1-15).
REQ-003 clock  in  1  single clock; all state changes on the rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  operation request.
REQ-006 req_ready  out  1  controller can accept a request.
REQ-007 req_op  in  5  ALU opcode (add 00011, sub 00100, shr 00101, shra 00110, shl 00111, ror 01000, rol 01001, and 01010, or 01011, mul 01111, div 10000, neg 10001, not 10010).
REQ-008 req_ra, req_rb, req_rd  in  4 each  source A, source B and destination register indices.
REQ-009 rf_rd_addr  out  4  register-file read index driven onto the bus.
REQ-010 rf_out_en  out  1  register-file read drives the bus.
REQ-011 y_in  out  1  load Y register (ALU A operand) from the bus.
REQ-012 alu_ops  out  5  opcode presented to the ALU.
REQ-013 z_in  out  1  load 64-bit Z register from the ALU result.
REQ-014 zlo_out, zhi_out  out  1 each  drive Z[31:0] or Z[63:32] onto the bus.
REQ-015 rf_wr_en  out  1, rf_wr_addr  out  4  register-file write from the bus.
REQ-016 lo_in, hi_in  out  1 each  load LO or HI from the bus.
REQ-017 done  out  1  one-cycle pulse marking the final cycle of an operation.
REQ-018 illegal  out  1  one-cycle pulse marking a rejected opcode.

Function
REQ-019 SHALL implement states IDLE, T_RA, T_EXEC, T_WB, T_LO, T_HI, T_ERR.
REQ-020 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid and req_ready are both 1; req_op/req_ra/req_rb/req_rd SHALL be captured then.
REQ-021 On acceptance, a legal opcode SHALL go to T_RA; any other opcode SHALL go to T_ERR.
REQ-022 T_RA (1 cycle): rf_rd_addr=ra, rf_out_en=1, y_in=1.
REQ-023 T_EXEC: alu_ops=captured op throughout; rf_rd_addr=rb and rf_out_en=1, except for neg and not, where rf_out_en=0.
REQ-024 T_EXEC length SHALL be 1 cycle for non-mul/div ops, MUL_CYCLES for mul, DIV_CYCLES for div, tracked by a 4-bit down-counter; z_in=1 only in the last T_EXEC cycle.
REQ-025 After T_EXEC, non-mul/div ops SHALL go to T_WB: zlo_out=1, rf_wr_en=1, rf_wr_addr=rd, done=1; then IDLE.
REQ-026 After T_EXEC, mul/div SHALL go to T_LO (zlo_out=1, lo_in=1), then T_HI (zhi_out=1, hi_in=1, done=1); then IDLE.
REQ-027 T_ERR (1 cycle): illegal=1, no other strobe asserted; then IDLE.
REQ-028 In any state, strobes not listed for that state SHALL be 0, and alu_ops SHALL be 00000 outside T_EXEC.
REQ-029 Latency, from the acceptance edge to done high: add = 3 cycles; mul = 3+MUL_CYCLES cycles; div = 3+DIV_CYCLES cycles.
REQ-030 The earliest following acceptance SHALL be on the edge after done or illegal, giving back-to-back throughput with one idle cycle.
REQ-031 req_valid while busy SHALL be ignored; the request is not queued.

Reset
REQ-032 reset_n low SHALL immediately force IDLE, counter=0, captured fields=0, all strobes and done/illegal=0, alu_ops=00000 and req_ready=1, even mid-operation; no partial write completes.

Configuration
REQ-033 With macro ALU_SEQ_MULDIV_EN defined, mul and div SHALL be legal and follow REQ-024/REQ-026.
REQ-034 Without ALU_SEQ_MULDIV_EN, mul and div SHALL be treated as illegal (T_ERR); the T_LO/T_HI states and their logic SHALL be omitted.

Structure
REQ-035 Opcode constants, the state enumeration and the bus-strobe bundle SHALL live in shared package cpu_ctrl_pkg.
REQ-036 Submodule alu_seq_timer SHALL hold the loadable 4-bit down-counter, with load, terminal-count and clear.

Verification
REQ-038 Accept add (00011, ra=1, rb=2, rd=3): T_RA rf_rd_addr=1 y_in=1; T_EXEC alu_ops=00011 rf_rd_addr=2 z_in=1; T_WB rf_wr_addr=3 done=1; done exactly 3 cycles after acceptance.
REQ-039 mul with MUL_CYCLES=2 and macro defined: alu_ops=01111 for 2 cycles, z_in only on the 2nd; lo_in then hi_in on consecutive cycles; done with hi_in at cycle 5.
REQ-040 not (10010): rf_out_en=0 in T_EXEC, result written to rd, done at cycle 3.
REQ-041 Opcode 11111: illegal pulses 1 cycle, no strobes; req_ready returns to 1 the next cycle; same for div when the macro is undefined.
REQ-042 reset_n pulsed low during the 3rd T_EXEC cycle of div: all outputs 0 and req_ready=1 asynchronously; lo_in/hi_in never asserted.
REQ-043 req_valid held high continuously with 2 adds: the 2nd is accepted on the edge after the 1st done; req_valid toggling while busy has no effect.
